// File: rtl/inst_fetch_pkg.sv
// Shared widths, opcodes and helpers for the fetch stage.
// Opcodes follow the MIPS-style encoding in inst[31:26].
package inst_fetch_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_BLEZ   = 6'd6;
  localparam logic [5:0] OP_BGTZ   = 6'd7;

  localparam logic [WORD_W-1:0] BUBBLE = '0;

  function automatic logic is_cond_branch(
    input logic [5:0] op
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      op == OP_REGIMM: r = 1'b1;
      op == OP_BEQ:    r = 1'b1;
      op == OP_BNE:    r = 1'b1;
      op == OP_BLEZ:   r = 1'b1;
      op == OP_BGTZ:   r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_branch_predictor.sv
// Branch history table of 2-bit saturating counters.
// Reads see the pre-update value of a same-cycle write.
module branch_predictor #(
  parameter int BHT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BHT_BITS-1:0] rd_idx,
  output logic [1:0]          rd_cnt,
  input  logic                upd_en,
  input  logic [BHT_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int N = 1 << BHT_BITS;

  logic [1:0] bht [N];

  assign rd_cnt = bht[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        bht[i] <= 2'b01;
    end else if (upd_en) begin
      if (upd_taken) begin
        if (bht[upd_idx] != 2'b11)
          bht[upd_idx] <= bht[upd_idx] + 2'b01;
      end else begin
        if (bht[upd_idx] != 2'b00)
          bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC selection, branch prediction and IF/ID register.
// Execute-stage redirects outrank decode stalls and jumps.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          BHT_BITS = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              stall,
  input  logic              force_jump,
  input  logic [WORD_W-1:0] next_pc,
  input  logic              ex_branch_valid,
  input  logic              ex_branch_actual,
  input  logic              ex_branch_pred,
  input  logic [WORD_W-1:0] ex_pc,
  input  logic [WORD_W-1:0] ex_branch_pc,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] if_pc,
  output logic              if_branch_taken
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] imm_ext;
  logic [WORD_W-1:0] target;
  logic [WORD_W-1:0] redirect;
  logic [1:0]        rd_cnt;
  logic              pred_taken;
  logic              mispredict;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign imm_ext   = {{14{imem_data[15]}},
                      imem_data[15:0], 2'b00};
  assign target    = pc_plus4 + imm_ext;

  assign pred_taken =
    is_cond_branch(imem_data[31:26]) &&
    (rd_cnt >= 2'd2);

  assign mispredict = ex_branch_valid &&
    (ex_branch_actual != ex_branch_pred);

  assign redirect = ex_branch_actual ?
    ex_branch_pc : ex_pc + 32'd4;

  branch_predictor #(
    .BHT_BITS(BHT_BITS)
  ) u_bp (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc[BHT_BITS+1:2]),
    .rd_cnt   (rd_cnt),
    .upd_en   (ex_branch_valid),
    .upd_idx  (ex_pc[BHT_BITS+1:2]),
    .upd_taken(ex_branch_actual)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (mispredict) begin
      pc <= redirect;
    end else if (stall) begin
      pc <= pc;
    end else if (force_jump) begin
      pc <= next_pc;
    end else if (pred_taken) begin
      pc <= target;
    end else begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || mispredict ||
        (force_jump && !stall)) begin
      inst            <= BUBBLE;
      if_pc           <= '0;
      if_branch_taken <= 1'b0;
    end else if (!stall) begin
      inst            <= imem_data;
      if_pc           <= pc;
      if_branch_taken <= pred_taken;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for the fetch stage.
// Expected values are hand-computed per step.
module tb_inst_fetch;

  localparam logic [31:0] ADDI = 32'h2001_0001;
  localparam logic [31:0] BEQ  = 32'h1000_0003;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        force_jump;
  logic [31:0] next_pc;
  logic        ex_branch_valid;
  logic        ex_branch_actual;
  logic        ex_branch_pred;
  logic [31:0] ex_pc;
  logic [31:0] ex_branch_pc;
  logic [31:0] inst;
  logic [31:0] if_pc;
  logic        if_branch_taken;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    imem_data = ADDI;
    if (imem_addr == 32'h20)
      imem_data = BEQ;
  end

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .force_jump      (force_jump),
    .next_pc         (next_pc),
    .ex_branch_valid (ex_branch_valid),
    .ex_branch_actual(ex_branch_actual),
    .ex_branch_pred  (ex_branch_pred),
    .ex_pc           (ex_pc),
    .ex_branch_pc    (ex_branch_pc),
    .inst            (inst),
    .if_pc           (if_pc),
    .if_branch_taken (if_branch_taken)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(
    input string       tag,
    input logic [31:0] e_pc,
    input logic [31:0] e_inst,
    input logic [31:0] e_ifpc,
    input logic        e_bt
  );
    check({tag, "_pc"}, imem_addr, e_pc);
    check({tag, "_inst"}, inst, e_inst);
    check({tag, "_ifpc"}, if_pc, e_ifpc);
    check({tag, "_bt"}, {31'd0, if_branch_taken},
          {31'd0, e_bt});
  endtask

  task automatic chk_bht8(
    input string      tag,
    input logic [1:0] e
  );
    check(tag, {30'd0, dut.u_bp.bht[8]}, {30'd0, e});
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    force_jump = 1'b0;
    next_pc = '0;
    ex_branch_valid = 1'b0;
    ex_branch_actual = 1'b0;
    ex_branch_pred = 1'b0;
    ex_pc = '0;
    ex_branch_pc = '0;
    step();
    step();
    chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    step();
    chk_ifid("f1", 32'h4, ADDI, 32'h0, 1'b0);
    step();
    chk_ifid("f2", 32'h8, ADDI, 32'h4, 1'b0);
    for (int i = 0; i < 16; i++)
      check($sformatf("bht%0d", i),
            {30'd0, dut.u_bp.bht[i]}, 32'd1);

    stall = 1'b1;
    step();
    chk_ifid("st1", 32'h8, ADDI, 32'h4, 1'b0);
    step();
    chk_ifid("st2", 32'h8, ADDI, 32'h4, 1'b0);
    stall = 1'b0;
    step();
    chk_ifid("res1", 32'hC, ADDI, 32'h8, 1'b0);
    step();
    chk_ifid("res2", 32'h10, ADDI, 32'hC, 1'b0);

    force_jump = 1'b1;
    next_pc = 32'h40;
    step();
    chk_ifid("jmp", 32'h40, 32'h0, 32'h0, 1'b0);
    next_pc = 32'h20;
    step();
    check("jmp20", imem_addr, 32'h20);

    // train while fetching the branch: read sees old 01
    force_jump = 1'b0;
    ex_branch_valid = 1'b1;
    ex_branch_actual = 1'b1;
    ex_branch_pred = 1'b1;
    ex_pc = 32'h20;
    step();
    chk_ifid("tr1", 32'h24, BEQ, 32'h20, 1'b0);
    chk_bht8("bht8_10", 2'b10);
    force_jump = 1'b1;
    step();
    chk_ifid("tr2", 32'h20, 32'h0, 32'h0, 1'b0);
    chk_bht8("bht8_11", 2'b11);
    force_jump = 1'b0;
    ex_branch_valid = 1'b0;
    step();
    chk_ifid("pred", 32'h30, BEQ, 32'h20, 1'b1);

    ex_branch_valid = 1'b1;
    ex_branch_actual = 1'b0;
    ex_branch_pred = 1'b1;
    stall = 1'b1;
    step();
    chk_ifid("misp", 32'h24, 32'h0, 32'h0, 1'b0);
    chk_bht8("bht8_dec", 2'b10);

    ex_branch_actual = 1'b1;
    ex_branch_pred = 1'b0;
    ex_branch_pc = 32'h80;
    stall = 1'b0;
    step();
    chk_ifid("mispt", 32'h80, 32'h0, 32'h0, 1'b0);
    chk_bht8("bht8_sat", 2'b11);
    ex_branch_valid = 1'b0;
    stall = 1'b1;
    step();
    check("st80", imem_addr, 32'h80);

    rst = 1'b1;
    step();
    chk_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_bht8("bht8_rst", 2'b01);

    rst = 1'b0;
    stall = 1'b0;
    force_jump = 1'b1;
    next_pc = 32'hFFFF_FFFC;
    step();
    check("top", imem_addr, 32'hFFFF_FFFC);
    force_jump = 1'b0;
    step();
    chk_ifid("wrap", 32'h0, ADDI,
             32'hFFFF_FFFC, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter BHT_BITS, default 4, sets log2 of the branch-history-table entry count (16 entries).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  32  fetch address (current PC); combinational from the PC register.
REQ-006 imem_data  input  32  instruction at imem_addr, valid in the same cycle.
REQ-007 stall  input  1  from decode: hold the IF/ID register and the PC.
REQ-008 force_jump  input  1  from decode: the instruction in decode is j/jal/jr.
REQ-009 next_pc  input  32  from decode: jump target, valid when force_jump=1.
REQ-010 ex_branch_valid  input  1  execute resolves a conditional branch this cycle.
REQ-011 ex_branch_actual  input  1  resolved direction (1 = taken).
REQ-012 ex_branch_pred  input  1  prediction carried with that branch.
REQ-013 ex_pc  input  32  PC of the resolving branch.
REQ-014 ex_branch_pc  input  32  resolved taken target.
REQ-015 inst  output  32  IF/ID instruction register.
REQ-016 if_pc  output  32  IF/ID PC register.
REQ-017 if_branch_taken  output  1  IF/ID prediction bit.

Function
REQ-018 Conditional branch: opcode 1, 4, 5, 6 or 7.
REQ-019 Predicted-taken branch: the fetched instruction is a conditional branch and BHT[pc[BHT_BITS+1:2]] >= 2.
REQ-020 Predicted target = pc + 4 + (sign-extended imm[15:0] << 2), modulo 2^32.
REQ-021 mispredict = ex_branch_valid && (ex_branch_actual != ex_branch_pred).
REQ-022 Next-PC priority:
  (1) mispredict -> ex_branch_actual ? ex_branch_pc : ex_pc+4;
  (2) stall -> PC held;
  (3) force_jump -> next_pc;
  (4) predicted-taken -> target;
  (5) otherwise -> pc+4.
REQ-023 IF/ID on mispredict: load bubble (inst=0, if_pc=0, if_branch_taken=0); mispredict overrides stall.
REQ-024 IF/ID on stall without mispredict: hold all three registers.
REQ-025 IF/ID on force_jump without stall or mispredict: load bubble.
REQ-026 IF/ID otherwise: inst<=imem_data, if_pc<=pc, if_branch_taken<=predicted-taken.
REQ-027 Fetch-to-decode latency is exactly one cycle.
REQ-028 BHT counters are 2-bit saturating.
REQ-029 On ex_branch_valid, BHT[ex_pc[BHT_BITS+1:2]] increments (saturates at 3) if taken, else decrements (saturates at 0); the update is independent of stall.
REQ-030 A BHT update and a BHT read of the same index in one cycle: the read returns the pre-update value.
REQ-031 PC increment wraps 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-032 When rst=1 at a clock edge: pc<=RESET_PC; inst, if_pc, if_branch_taken <= 0; every BHT entry <= 2'b01 (weakly not-taken).
REQ-033 rst overrides stall, mispredict and force_jump in the same cycle.
REQ-034 The first fetch from RESET_PC occurs in the cycle after rst deasserts.

Structure
REQ-035 The shared define package holds the `WORD/`REG widths, the opcode constants (BEQ=4, BNE=5, BLEZ=6, BGTZ=7, REGIMM=1) and the bubble value.
REQ-036 The BHT, with its read port, update port and saturating logic, is one sub-module named branch_predictor.

Verification
REQ-037 Reset, then 3 cycles, with imem returning addi: imem_addr = 0, 4, 8; if_pc lags imem_addr by one cycle; the BHT is all 01.
REQ-038 stall=1 for 2 cycles at pc=8: pc stays 8 and inst/if_pc are held; fetch resumes at 8 then 12.
REQ-039 force_jump=1, next_pc=0x40 at pc=0x10: next imem_addr = 0x40; inst = 0 in the following cycle.
REQ-040 beq at 0x20 with imm=3, resolved taken twice: BHT[8] goes 01->10->11; the next fetch of 0x20 predicts 0x30 with if_branch_taken=1.
REQ-041 Simultaneous mispredict (ex_pc=0x20, actual=0, pred=1) and stall=1: pc<=0x24 and IF/ID is a bubble.
REQ-042 rst asserted mid-stall at pc=0x80: next cycle imem_addr = 0 and all outputs are 0.
